// File: rtl/zx_bus_pkg.sv
// Shared definitions for the Z80-side bus initiator: request kinds, half-state
// encodings and per-kind T-state counts.
package zx_bus_pkg;

  localparam logic [2:0] KIND_MEMRD  = 3'd0;
  localparam logic [2:0] KIND_MEMWR  = 3'd1;
  localparam logic [2:0] KIND_IORD   = 3'd2;
  localparam logic [2:0] KIND_IOWR   = 3'd3;
  localparam logic [2:0] KIND_FETCH  = 3'd4;
  localparam logic [2:0] KIND_INTACK = 3'd5;

  // Bit 0 clear marks the PHI-high half of every T-state.
  localparam logic [3:0] ST_IDLE_H = 4'd0;
  localparam logic [3:0] ST_IDLE_L = 4'd1;
  localparam logic [3:0] ST_T1H    = 4'd2;
  localparam logic [3:0] ST_T1L    = 4'd3;
  localparam logic [3:0] ST_T2H    = 4'd4;
  localparam logic [3:0] ST_T2L    = 4'd5;
  localparam logic [3:0] ST_TWH    = 4'd6;
  localparam logic [3:0] ST_TWL    = 4'd7;
  localparam logic [3:0] ST_T3H    = 4'd8;
  localparam logic [3:0] ST_T3L    = 4'd9;
  localparam logic [3:0] ST_T4H    = 4'd10;
  localparam logic [3:0] ST_T4L    = 4'd11;

  localparam int unsigned TSTATES_MEM   = 3;
  localparam int unsigned TSTATES_IO    = 3;
  localparam int unsigned TSTATES_FETCH = 4;

  function automatic int unsigned tstates_of(input logic [2:0] kind);
    int unsigned n;
    case (kind)
      KIND_FETCH:                         n = TSTATES_FETCH;
      KIND_IORD, KIND_IOWR, KIND_INTACK:  n = TSTATES_IO;
      default:                            n = TSTATES_MEM;
    endcase
    return n;
  endfunction

  function automatic logic is_io_like(input logic [2:0] kind);
    return (kind == KIND_IORD) || (kind == KIND_IOWR) || (kind == KIND_INTACK);
  endfunction

  function automatic logic is_read(input logic [2:0] kind);
    return (kind == KIND_MEMRD) || (kind == KIND_IORD) ||
           (kind == KIND_FETCH) || (kind == KIND_INTACK);
  endfunction

  function automatic logic is_reserved(input logic [2:0] kind);
    return kind > KIND_INTACK;
  endfunction

endpackage

// File: rtl/zx_refresh_ctr.sv
// Z80 refresh register: low seven bits count, bit 7 is preserved across increments.
module zx_refresh_ctr
#(
  parameter logic [6:0] R_INIT = 7'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] r
);

  logic [6:0] r_lo_reg;
  logic       r_hi_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo_reg <= R_INIT;
      r_hi_reg <= 1'b0;
    end else if (inc) begin
      r_lo_reg <= r_lo_reg + 7'd1;
    end
  end

  assign r = {r_hi_reg, r_lo_reg};

endmodule

// File: rtl/zx_bus_initiator.sv
// Z80 bus-cycle generator: turns valid/ready requests into half-T-state accurate
// MREQ/IORQ/RD/WR/M1/RFSH sequences and returns one response per completed cycle.
module zx_bus_initiator
  import zx_bus_pkg::*;
#(
  parameter int unsigned AUTO_IO_WAIT = 1,
  parameter logic [6:0]  R_INIT       = 7'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [7:0]  i_reg,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        phi,
  output logic        n_mreq,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_m1,
  output logic        n_rfsh,
  output logic [15:0] addr,
  output logic        addr_n_oe,
  output logic [7:0]  data_out,
  output logic        data_n_oe,
  input  logic [7:0]  data_in,
  input  logic        n_wait,
  input  logic        n_int,
  output logic        int_pending
);

  logic [3:0] state_reg, state_next;
  logic [2:0] kind_reg;
  logic [7:0] wdata_reg;
  logic [1:0] wait_cnt_reg;
  logic       req_ready_reg;
  logic       accept, io_like, more_auto, r_inc;
  logic [2:0] waits_done;
  logic [7:0] r_val;

  assign accept     = req_valid && req_ready_reg && (state_reg == ST_IDLE_L);
  assign io_like    = is_io_like(kind_reg);
  assign waits_done = {1'b0, wait_cnt_reg} + 3'd1;
  assign more_auto  = io_like && (32'(waits_done) < AUTO_IO_WAIT);
  assign r_inc      = (state_reg == ST_T4L) ||
                      ((state_reg == ST_T3L) && (kind_reg == KIND_INTACK));
  assign req_ready  = req_ready_reg;
  assign phi        = ~state_reg[0];

  zx_refresh_ctr #(.R_INIT(R_INIT)) u_refresh (
    .clk   (clk),
    .reset (reset),
    .inc   (r_inc),
    .r     (r_val)
  );

  always_comb begin
    state_next = ST_IDLE_L;
    case (state_reg)
      ST_IDLE_H: state_next = ST_IDLE_L;
      ST_IDLE_L: state_next = (accept && !is_reserved(req_kind)) ? ST_T1H : ST_IDLE_H;
      ST_T1H:    state_next = ST_T1L;
      ST_T1L:    state_next = ST_T2H;
      ST_T2H:    state_next = ST_T2L;
      // I/O-like cycles always enter the automatic waits; memory cycles sample WAIT here.
      ST_T2L:    state_next = ((io_like && (AUTO_IO_WAIT != 0)) || !n_wait) ? ST_TWH : ST_T3H;
      ST_TWH:    state_next = ST_TWL;
      ST_TWL:    state_next = (more_auto || !n_wait) ? ST_TWH : ST_T3H;
      ST_T3H:    state_next = ST_T3L;
      ST_T3L:    state_next = (tstates_of(kind_reg) == TSTATES_FETCH) ? ST_T4H : ST_IDLE_H;
      ST_T4H:    state_next = ST_T4L;
      ST_T4L:    state_next = ST_IDLE_H;
      default:   state_next = ST_IDLE_L;
    endcase
  end

  // Outputs are registered and change on entry to the half-state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE_L;
      req_ready_reg <= 1'b0;
      kind_reg      <= KIND_MEMRD;
      wdata_reg     <= 8'h00;
      wait_cnt_reg  <= 2'd0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 8'h00;
      int_pending   <= 1'b0;
      n_mreq        <= 1'b1;
      n_iorq        <= 1'b1;
      n_rd          <= 1'b1;
      n_wr          <= 1'b1;
      n_m1          <= 1'b1;
      n_rfsh        <= 1'b1;
      addr          <= 16'h0000;
      addr_n_oe     <= 1'b1;
      data_out      <= 8'h00;
      data_n_oe     <= 1'b1;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= (state_next == ST_IDLE_L);
      resp_valid    <= 1'b0;
      case (state_next)
        ST_T1H: begin
          kind_reg     <= req_kind;
          wdata_reg    <= req_wdata;
          addr         <= req_addr;
          addr_n_oe    <= 1'b0;
          n_m1         <= !((req_kind == KIND_FETCH) || (req_kind == KIND_INTACK));
          wait_cnt_reg <= 2'd0;
        end
        ST_T1L: begin
          if ((kind_reg == KIND_MEMRD) || (kind_reg == KIND_FETCH)) begin
            n_mreq <= 1'b0;
            n_rd   <= 1'b0;
          end else if (kind_reg == KIND_MEMWR) begin
            n_mreq    <= 1'b0;
            data_out  <= wdata_reg;
            data_n_oe <= 1'b0;
          end
        end
        ST_T2H: begin
          if (kind_reg == KIND_IORD) begin
            n_iorq <= 1'b0;
            n_rd   <= 1'b0;
          end else if (kind_reg == KIND_IOWR) begin
            n_iorq    <= 1'b0;
            n_wr      <= 1'b0;
            data_out  <= wdata_reg;
            data_n_oe <= 1'b0;
          end
        end
        ST_T2L: begin
          if (kind_reg == KIND_MEMWR) n_wr <= 1'b0;
        end
        ST_TWL: begin
          if ((kind_reg == KIND_INTACK) && (wait_cnt_reg == 2'd0)) n_iorq <= 1'b0;
        end
        ST_T3H: begin
          resp_rdata <= is_read(kind_reg) ? data_in : 8'h00;
          if (kind_reg == KIND_FETCH) begin
            n_mreq <= 1'b1;
            n_rd   <= 1'b1;
            n_m1   <= 1'b1;
            n_rfsh <= 1'b0;
            addr   <= {i_reg, r_val};
          end else if (kind_reg == KIND_INTACK) begin
            n_m1   <= 1'b1;
            n_iorq <= 1'b1;
          end
        end
        ST_T3L: begin
          if (kind_reg == KIND_FETCH) n_mreq <= 1'b0;
        end
        ST_IDLE_H: begin
          if (accept) begin
            resp_valid <= 1'b1;
            resp_rdata <= 8'h00;
          end else if ((state_reg == ST_T3L) || (state_reg == ST_T4L)) begin
            n_mreq      <= 1'b1;
            n_iorq      <= 1'b1;
            n_rd        <= 1'b1;
            n_wr        <= 1'b1;
            n_m1        <= 1'b1;
            n_rfsh      <= 1'b1;
            data_n_oe   <= 1'b1;
            resp_valid  <= 1'b1;
            int_pending <= !n_int;
          end
        end
        default: ;
      endcase
      if ((state_reg == ST_TWL) && (wait_cnt_reg != 2'd3)) wait_cnt_reg <= wait_cnt_reg + 2'd1;
    end
  end

endmodule

// File: tb/tb_zx_bus_initiator.sv
// Self-checking bench for zx_bus_initiator: expected waveforms come from per-kind
// strobe windows expressed in half-T-state indices after request acceptance.
module tb_zx_bus_initiator;

  localparam int         AUTO  = 1;
  localparam logic [6:0] RINIT = 7'h7F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = 3'd0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic [7:0]  i_reg = 8'h00;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        phi, n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh;
  logic [15:0] addr;
  logic        addr_n_oe;
  logic [7:0]  data_out;
  logic        data_n_oe;
  logic [7:0]  data_in = 8'h00;
  logic        n_wait = 1'b1;
  logic        n_int = 1'b1;
  logic        int_pending;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  logic [6:0] r_model = RINIT;
  logic       int_model = 1'b0;

  zx_bus_initiator #(.AUTO_IO_WAIT(AUTO), .R_INIT(RINIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_addr(req_addr), .req_wdata(req_wdata), .i_reg(i_reg),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .phi(phi),
    .n_mreq(n_mreq), .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_m1(n_m1), .n_rfsh(n_rfsh),
    .addr(addr), .addr_n_oe(addr_n_oe), .data_out(data_out), .data_n_oe(data_n_oe),
    .data_in(data_in), .n_wait(n_wait), .n_int(n_int), .int_pending(int_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit in_rng(input int i, input int a, input int b);
    return (i >= a) && (i <= b);
  endfunction

  // {n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh} at half-state index i of a cycle.
  function automatic logic [5:0] exp_strobes(input int kind, input int i, input int len, input int t3h);
    logic mreq, iorq, rd, wr, m1, rfsh;
    mreq = 1; iorq = 1; rd = 1; wr = 1; m1 = 1; rfsh = 1;
    case (kind)
      0: begin mreq = !in_rng(i, 1, len-1); rd = mreq; end
      1: begin mreq = !in_rng(i, 1, len-1); wr = !in_rng(i, 3, len-1); end
      2: begin iorq = !in_rng(i, 2, len-1); rd = iorq; end
      3: begin iorq = !in_rng(i, 2, len-1); wr = iorq; end
      4: begin
        m1   = !in_rng(i, 0, t3h-1);
        rd   = !in_rng(i, 1, t3h-1);
        mreq = !(in_rng(i, 1, t3h-1) || in_rng(i, t3h+1, len-1));
        rfsh = !in_rng(i, t3h, len-1);
      end
      5: begin m1 = !in_rng(i, 0, t3h-1); iorq = !in_rng(i, 5, t3h-1); end
      default: ;
    endcase
    return {mreq, iorq, rd, wr, m1, rfsh};
  endfunction

  task automatic do_txn(input logic [2:0] kind, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] din, input int extra, input logic nint_last,
                        input bit keep, input bit chk_gap);
    int w, len, t3h, sstart, k;
    bit res, io, fetch, rdk, eoe;
    logic [5:0] es, os;
    logic [15:0] ea;
    logic [7:0] erd;
    logic eint;
    res    = kind > 3'd5;
    io     = (kind == 3'd2) || (kind == 3'd3) || (kind == 3'd5);
    fetch  = kind == 3'd4;
    rdk    = (kind == 3'd0) || (kind == 3'd2) || fetch || (kind == 3'd5);
    w      = io ? AUTO + extra : extra;
    len    = res ? 0 : 2 * (3 + w) + (fetch ? 2 : 0);
    t3h    = 4 + 2 * w;
    sstart = io ? 3 + 2 * AUTO : 3;
    erd    = (rdk && !res) ? din : 8'h00;
    eint   = res ? int_model : !nint_last;
    req_kind = kind; req_addr = a; req_wdata = wd; data_in = din; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 40) begin @(negedge clk); k++; end
    total++;
    if (!req_ready) begin
      $display("FAIL accept_timeout kind=%0d got req_ready=0 want 1", kind);
      bad++;
      req_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      if (i == 0 && !keep) req_valid = 1'b0;
      if (!res && i >= sstart && i <= sstart + 2 * extra && ((i - sstart) % 2 == 0))
        n_wait = (i < sstart + 2 * extra) ? 1'b0 : 1'b1;
      else
        n_wait = 1'($urandom_range(0, 1));
      n_int = (i == len - 1) ? nint_last : 1'($urandom_range(0, 1));
      es = exp_strobes(int'(kind), i, len, t3h);
      os = {n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh};
      total++;
      if (os !== es) begin
        $display("FAIL strobes kind=%0d idx=%0d got=%b want=%b", kind, i, os, es); bad++;
      end
      total++;
      if (phi !== ((i % 2) == 0)) begin
        $display("FAIL phi kind=%0d idx=%0d got=%b want=%b", kind, i, phi, ((i % 2) == 0)); bad++;
      end
      eoe = ((kind == 3'd1) && in_rng(i, 1, len-1)) || ((kind == 3'd3) && in_rng(i, 2, len-1));
      total++;
      if (data_n_oe !== !eoe || (eoe && data_out !== wd)) begin
        $display("FAIL data_bus kind=%0d idx=%0d got oe_n=%b d=%h want oe_n=%b d=%h",
                 kind, i, data_n_oe, data_out, !eoe, wd); bad++;
      end
      if (!res) begin
        ea = (fetch && i >= t3h) ? {i_reg, 1'b0, r_model} : a;
        total++;
        if (addr !== ea || addr_n_oe !== 1'b0) begin
          $display("FAIL addr kind=%0d idx=%0d got=%h oe_n=%b want=%h oe_n=0",
                   kind, i, addr, addr_n_oe, ea); bad++;
        end
      end
      if (i < len) begin
        total++;
        if (resp_valid !== 1'b0) begin
          $display("FAIL early_resp kind=%0d idx=%0d got=%b want=0", kind, i, resp_valid); bad++;
        end
      end else begin
        total++;
        if (resp_valid !== 1'b1) begin
          $display("FAIL resp_valid kind=%0d idx=%0d got=%b want=1", kind, i, resp_valid); bad++;
        end
        total++;
        if (resp_rdata !== erd) begin
          $display("FAIL rdata kind=%0d got=%h want=%h", kind, resp_rdata, erd); bad++;
        end
        total++;
        if (int_pending !== eint) begin
          $display("FAIL int_pending kind=%0d got=%b want=%b", kind, int_pending, eint); bad++;
        end
        if (chk_gap) begin
          total++;
          if (cyc - last_resp_cyc !== len + 2) begin
            $display("FAIL resp_gap kind=%0d got=%0d want=%0d", kind, cyc - last_resp_cyc, len + 2); bad++;
          end
        end
        last_resp_cyc = cyc;
      end
    end
    int_model = eint;
    if (!res && (fetch || kind == 3'd5)) r_model = r_model + 7'd1;
    $display("txn kind=%0d addr=%h wd=%h din=%h waits=%0d len=%0d rdata=%h int=%b",
             kind, a, wd, din, w, len, resp_rdata, int_pending);
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh} !== 6'h3F || data_n_oe !== 1'b1 ||
        addr_n_oe !== 1'b1 || addr !== 16'h0000 || data_out !== 8'h00) begin
      $display("FAIL %s_bus got strobes=%b doe_n=%b aoe_n=%b addr=%h d=%h want 111111 1 1 0000 00", tag,
               {n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh}, data_n_oe, addr_n_oe, addr, data_out); bad++;
    end
    total++;
    if (phi !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0 ||
        resp_rdata !== 8'h00 || int_pending !== 1'b0) begin
      $display("FAIL %s_ctl got phi=%b rdy=%b rv=%b rd=%h ip=%b want all 0", tag,
               phi, req_ready, resp_valid, resp_rdata, int_pending); bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    r_model = RINIT; int_model = 1'b0;
  endtask

  task automatic test_memrd();
    do_txn(3'd0, 16'h4000, 8'h00, 8'hA5, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_memwr_wait();
    do_txn(3'd1, 16'h5800, 8'h3C, 8'h00, 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_iord();
    do_txn(3'd2, 16'h00FE, 8'h00, 8'hBF, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    i_reg = 8'h3F;
    total++;
    if (r_model !== 7'h7F) begin
      $display("FAIL b2b_rstart got=%h want=7f", r_model); bad++;
    end
    do_txn(3'd4, 16'h0000, 8'h00, 8'h11, 0, 1'b1, 1'b1, 1'b0);
    do_txn(3'd4, 16'h0001, 8'h00, 8'h22, 0, 1'b1, 1'b1, 1'b1);
    do_txn(3'd4, 16'h0002, 8'h00, 8'h33, 0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_intack();
    do_txn(3'd5, 16'h1234, 8'h00, 8'hFF, 0, 1'b0, 1'b0, 1'b0);
    do_txn(3'd4, 16'h0100, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midcycle();
    int k;
    req_kind = 3'd1; req_addr = 16'h5800; req_wdata = 8'h3C; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 40) begin @(negedge clk); k++; end
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      n_wait = 1'b0;
    end
    total++;
    if (n_wr !== 1'b0 || data_n_oe !== 1'b0) begin
      $display("FAIL midrst_pre got n_wr=%b doe_n=%b want 0 0", n_wr, data_n_oe); bad++;
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) reset = 1'b0;
      total++;
      if (resp_valid !== 1'b0) begin
        $display("FAIL midrst_resp idx=%0d got=%b want=0", i, resp_valid); bad++;
      end
    end
    n_wait = 1'b1;
    r_model = RINIT; int_model = 1'b0;
    do_txn(3'd0, 16'h4000, 8'h00, 8'h5A, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit prev_keep, keep;
    prev_keep = 1'b0;
    for (int n = 0; n < 40; n++) begin
      keep  = 1'($urandom_range(0, 1));
      i_reg = 8'($urandom_range(0, 255));
      do_txn(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), keep, prev_keep);
      prev_keep = keep;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_memrd();
    test_memwr_wait();
    test_iord();
    test_intack();
    test_reset_midcycle();
    test_random();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zx_bus_initiator.md
Name: zx_bus_initiator

Overview:
- Z80-side bus-cycle generator: the initiator end of the CPU bus that the ULA answers.
- It drives MREQ/IORQ/RD/WR/M1/RFSH, address and data with Z80 T-state timing, and samples WAIT, data and INT.
- It is used as the CPU stand-in for exercising the ULA netlist, and as the CPU-facing bus engine in the FPGA build.
- Transactions arrive over a valid/ready request port. Each completed cycle returns one response.

Parameters:
- AUTO_IO_WAIT, 1, number of automatic wait T-states inserted in I/O and INT-ack cycles (0..3).
- R_INIT, 7'h00, reset value of the 7-bit refresh counter.

Ports:
- clk  in  1  bus clock at 2x CPU PHI rate; each clk cycle is one half T-state (H = PHI high, L = PHI low).
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_kind  in  3  0 = MEMRD, 1 = MEMWR, 2 = IORD, 3 = IOWR, 4 = FETCH (M1 + refresh), 5 = INTACK; 6 and 7 are reserved.
- req_addr  in  16  cycle address.
- req_wdata  in  8  write data.
- i_reg  in  8  I register, used as the refresh address high byte.
- resp_valid  out  1  one-cycle pulse when a cycle completes.
- resp_rdata  out  8  sampled read data; 0 for writes.
- phi  out  1  CPU clock: 1 in H half-cycles, 0 in L half-cycles.
- n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh  out  1 each  active-low strobes.
- addr  out  16  address bus.
- addr_n_oe  out  1  0 = drive addr.
- data_out  out  8  data bus value.
- data_n_oe  out  1  0 = drive data.
- data_in  in  8  data bus sample.
- n_wait  in  1  active-low wait.
- n_int  in  1  active-low interrupt.
- int_pending  out  1  n_int sampled low at the last T-state of the most recent cycle.

Behaviour:
- Reset (async, asserted or released at any point, including mid-cycle):
  - all strobes = 1, addr_n_oe = 1, data_n_oe = 1, addr = 0, data_out = 0;
  - phi = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, int_pending = 0, R = R_INIT;
  - state = IDLE_L. An in-flight cycle is abandoned with no response.
- Half-state FSM: IDLE_H/IDLE_L, T1H, T1L, T2H, T2L, TWH, TWL, T3H, T3L, T4H, T4L.
  - phi toggles every clk in every state, including idle.
- req_ready = 1 only in IDLE_L.
  - Acceptance (req_valid & req_ready) latches kind, addr and wdata, then goes to T1H.
  - Reserved kinds are accepted, complete immediately with resp_valid and rdata = 0, and produce no bus activity.
- T1H: addr = req_addr, addr_n_oe = 0. For FETCH/INTACK, n_m1 = 0.
- T1L:
  - MEMRD/FETCH: n_mreq = 0, n_rd = 0.
  - MEMWR: n_mreq = 0, data_out = wdata, data_n_oe = 0.
- T2H:
  - IORD: n_iorq = 0, n_rd = 0.
  - IOWR: n_iorq = 0, n_wr = 0, data driven.
- T2L:
  - MEMWR: n_wr = 0.
  - n_wait is sampled here for memory cycles. If it is 0, go to TWH, else go to T3H.
- Wait states:
  - I/O and INTACK always insert AUTO_IO_WAIT TW states, then sample n_wait at the last TWL.
  - In any TWL, n_wait = 0 adds another TW. Waits are unbounded.
  - INTACK asserts n_iorq = 0 at the first TWL.
- T3H, data sampling:
  - MEMRD/IORD/FETCH/INTACK latch data_in into resp_rdata.
- T3H, FETCH only:
  - n_mreq = 1, n_rd = 1, n_m1 = 1, n_rfsh = 0;
  - addr = {i_reg, 1'b?R-bit7 preserved, R[6:0]}, i.e. {i_reg, R_hi, R[6:0]} with bit 7 of R held;
  - INTACK also releases n_m1 and n_iorq here and latches data.
- T3L:
  - FETCH: n_mreq = 0 (refresh).
  - All other kinds: all strobes released, data_n_oe = 1. Go to IDLE_H with resp_valid = 1 for one clk and n_int sampled into int_pending.
- FETCH continues through T4:
  - T4H holds the refresh state.
  - T4L: n_mreq = 1, n_rfsh = 1, R[6:0] increments modulo 128 with bit 7 unchanged, resp_valid = 1, int_pending sampled, then go to IDLE_H.
- INTACK also increments R at completion.
- Back-to-back: a request held valid is accepted at the first IDLE_L after completion. The minimum gap is 1 T-state of idle.
- Between cycles addr_n_oe stays 0 with the last address held; data_n_oe = 1.
- n_wait is ignored outside its sample points. n_int is ignored except at completion.

Decomposition:
- Shared package zx_bus_pkg holds:
  - the req_kind encoding constants;
  - the FSM state enum;
  - the T-state counts per kind (MEMRD/MEMWR/IO = 3 + waits, FETCH = 4).
- One sub-module, zx_refresh_ctr: the 7-bit R counter with preserved bit 7, an increment strobe, and reset to R_INIT.

Test Plan:
- MEMRD at 0x4000, n_wait = 1, data_in = 0xA5:
  - n_mreq/n_rd low from T1L through T3L;
  - resp_rdata = 0xA5 after 6 clk;
  - n_wr, n_iorq, n_m1 stay 1.
- MEMWR 0x5800 data 0x3C with n_wait held low for 2 T-states:
  - n_wr low from T2L through the two TW states and T3;
  - data_n_oe = 0 from T1L to T3L;
  - 10 clk total to resp_valid.
- IORD port 0x00FE, AUTO_IO_WAIT = 1, data_in = 0xBF:
  - n_iorq falls at T2H, never n_mreq;
  - resp_rdata = 0xBF at 8 clk.
- Three back-to-back FETCH with i_reg = 0x3F, R_INIT = 0x7F:
  - refresh addresses are 0x3F7F, 0x3F00, 0x3F01;
  - n_rfsh low during T3H..T4L;
  - resp spacing is 10 clk.
- INTACK with n_int low:
  - n_m1 low at T1H, n_iorq low at TW;
  - rdata = 0xFF;
  - int_pending = 1; R incremented.
- Reset asserted at T2L of MEMWR:
  - all strobes = 1 and data_n_oe = 1 in the same clk (async);
  - no resp_valid;
  - after release, a new MEMRD completes normally.
